// File: rtl/clb_defs.sv
// Shared CLB datapath definitions: lane count and select width for the 8-way mux/demux pair.
package clb_defs;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] lane_sel_t;
  typedef logic [LANES-1:0] lane_vec_t;

  function automatic lane_vec_t sel_onehot(input lane_sel_t sel);
    lane_vec_t one;
    one = {{(LANES-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/demux_lane_slot.sv
// One-entry valid/ready holding register for a single demux output lane.
module demux_lane_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q;
  logic             full_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // A push always wins over a pop, so a same-cycle push/pop replaces the word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= {WIDTH{1'b0}};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/demux_1x8_stream.sv
// Registered 1-to-8 stream demultiplexer: steers each accepted word into one
// of eight independent one-entry lane slots and counts accepted transfers.
module demux_1x8_stream
  import clb_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [WIDTH-1:0] out_data4,
  output logic [WIDTH-1:0] out_data5,
  output logic [WIDTH-1:0] out_data6,
  output logic [WIDTH-1:0] out_data7,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  lane_vec_t        full_s;
  lane_vec_t        push_s;
  lane_vec_t        pop_s;
  logic             accept_s;
  logic [WIDTH-1:0] lane_data_s [LANES];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The selected slot may be refilled in the same cycle it drains.
  assign in_ready = ~full_s[in_sel] | out_ready[in_sel];
  assign accept_s = in_valid & in_ready;
  assign pop_s    = full_s & out_ready;

  // Select decode: at most one lane is pushed per cycle.
  always_comb begin
    push_s = {LANES{1'b0}};
    if (accept_s) begin
      push_s = sel_onehot(in_sel);
    end else begin
      push_s = {LANES{1'b0}};
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .push_i (push_s[k]),
      .pop_i  (pop_s[k]),
      .data_i (in_data),
      .full_o (full_s[k]),
      .data_o (lane_data_s[k])
    );
  end

  // Accepted-transfer counter, wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = full_s;
  assign xfer_count = cnt_q;
  assign out_data0  = lane_data_s[0];
  assign out_data1  = lane_data_s[1];
  assign out_data2  = lane_data_s[2];
  assign out_data3  = lane_data_s[3];
  assign out_data4  = lane_data_s[4];
  assign out_data5  = lane_data_s[5];
  assign out_data6  = lane_data_s[6];
  assign out_data7  = lane_data_s[7];

endmodule
